// File: rtl/upcntr_ctrl_if.sv
// ---------------------------------------------------------------------------
// upcntr_ctrl_if -- control/status bundle for the upcntr_ctrl counter.
//
// Signals:
//   start   : request to begin a count sequence
//   pause   : level, freezes counting while high
//   abort   : terminates an active sequence without a done pulse
//   tc      : terminal count (WIDTH bits), latched on an accepted start
//   reload  : 1 = auto-reload, 0 = one-shot, latched on an accepted start
//   cnt     : current count value
//   busy    : sequence active (counting or held)
//   done    : one-cycle pulse per completed period
//   periods : completed periods since the last accepted start, saturating
//
// Modports:
//   master : drives the controls, observes the status (controller side)
//   slave  : the counter itself
// ---------------------------------------------------------------------------
interface upcntr_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] tc;
    logic             reload;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic [7:0]       periods;

    modport master (
        output start, pause, abort, tc, reload,
        input  cnt, busy, done, periods
    );

    modport slave (
        input  start, pause, abort, tc, reload,
        output cnt, busy, done, periods
    );
endinterface

// File: rtl/upcntr_ctrl.sv
// ---------------------------------------------------------------------------
// upcntr_ctrl -- programmable up-counter with one-shot / auto-reload modes.
//
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high reset
//   bus   : upcntr_ctrl_if.slave (start/pause/abort/tc/reload in,
//           cnt/busy/done/periods out; all outputs registered)
//
// A period runs cnt through 0..tc_q (tc_q + 1 cycles). In auto-reload mode
// the counter wraps to 0 with a done pulse; in one-shot mode it parks in
// DONE for one cycle holding tc_q, then returns to IDLE unless a new start
// arrives in that cycle. Priority per edge: reset > abort > pause > count.
// ---------------------------------------------------------------------------
module upcntr_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    upcntr_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] tc_q, tc_d;
    logic             reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       periods_q, periods_d;

    logic             at_tc;
    logic [7:0]       periods_inc;

    assign at_tc       = (cnt_q == tc_q);
    assign periods_inc = (periods_q == 8'hFF) ? periods_q : periods_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tc_d      = tc_q;
        reload_d  = reload_q;
        periods_d = periods_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = RUN;
                    tc_d      = bus.tc;
                    reload_d  = bus.reload;
                    cnt_d     = '0;
                    periods_d = 8'd0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end

            // HOLD only records that counting is frozen. A cycle with pause
            // low performs the normal count step immediately, so every cycle
            // pause is high delays completion by exactly one cycle.
            RUN, HOLD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (bus.pause) begin
                    state_d = HOLD;
                end else if (at_tc) begin
                    done_d    = 1'b1;
                    periods_d = periods_inc;
                    if (reload_q) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        // One-shot: cnt keeps showing tc_q during DONE.
                        state_d = DONE;
                    end
                end else begin
                    state_d = RUN;
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            tc_q      <= '0;
            reload_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            periods_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tc_q      <= tc_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            periods_q <= periods_d;
        end
    end

    assign bus.cnt     = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.periods = periods_q;
endmodule

// File: tb/tb_upcntr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_upcntr_ctrl -- self-checking bench for upcntr_ctrl (WIDTH = 4).
// Directed table, hand-written corner sequences and a randomized run, all
// compared against a behavioural model of the counter.
// ---------------------------------------------------------------------------
module tb_upcntr_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    upcntr_ctrl_if #(.WIDTH(W)) bus ();

    upcntr_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_bad    = 0;

    // Behavioural model: a sequence is either active (counting or frozen,
    // which look identical from outside apart from cnt not moving) or not.
    bit m_active;
    bit m_done_cycle;
    int m_cnt;
    int m_tc;
    bit m_reload;
    bit m_done;
    int m_periods;

    typedef struct {
        bit s; bit p; bit a; int t; bit r;
        int e_cnt; bit e_busy; bit e_done; int e_per;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input bit s, input bit p, input bit a, input int t, input bit r);
        bus.start  = s;
        bus.pause  = p;
        bus.abort  = a;
        bus.tc     = t[W-1:0];
        bus.reload = r;
    endtask

    task automatic model_step();
        if (reset) begin
            m_active = 0; m_done_cycle = 0; m_cnt = 0; m_tc = 0;
            m_reload = 0; m_done = 0; m_periods = 0;
        end else if (m_active) begin
            m_done = 0;
            if (bus.abort) begin
                m_active = 0;
                m_cnt = 0;
            end else if (!bus.pause) begin
                if (m_cnt == m_tc) begin
                    m_done = 1;
                    if (m_periods < 255) m_periods++;
                    if (m_reload) m_cnt = 0;
                    else begin
                        m_active = 0;
                        m_done_cycle = 1;
                    end
                end else begin
                    m_cnt = (m_cnt + 1) % (1 << W);
                end
            end
        end else begin
            m_done = 0;
            m_done_cycle = 0;
            m_cnt = 0;
            if (bus.start) begin
                m_active = 1;
                m_tc = int'(bus.tc);
                m_reload = bus.reload;
                m_periods = 0;
            end
        end
    endtask

    task automatic compare_model();
        check("cnt", int'(bus.cnt), m_cnt);
        check("busy", int'(bus.busy), int'(m_active));
        check("done", int'(bus.done), int'(m_done));
        check("periods", int'(bus.periods), m_periods);
    endtask

    task automatic tick(input bit chk);
        @(posedge clk);
        model_step();
        #1;
        if (chk) compare_model();
    endtask

    initial begin
        int edges;
        int dones;
        int busy_drops;
        int max_cnt;
        bit seen;

        // One-shot tc = 5: start, count 0..5, done cycle, back to IDLE.
        tbl[0] = '{1, 0, 0, 5, 0, 0, 1, 0, 0};
        tbl[1] = '{0, 0, 0, 9, 1, 1, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 9, 1, 2, 1, 0, 0};
        tbl[3] = '{1, 0, 0, 9, 1, 3, 1, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 4, 1, 0, 0};
        tbl[5] = '{0, 0, 0, 0, 0, 5, 1, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 5, 0, 1, 1};
        tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

        // Reset state with start asserted: start must not be taken.
        set_in(1, 0, 0, 7, 1);
        reset = 1'b1;
        tick(0);
        tick(1);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_cnt", int'(bus.cnt), 0);
        check("rst_periods", int'(bus.periods), 0);
        $display("reset: cnt=%0d busy=%0d done=%0d periods=%0d", bus.cnt, bus.busy, bus.done, bus.periods);
        reset = 1'b0;

        // Directed one-shot table (first start on first edge after reset).
        for (int i = 0; i < 8; i++) begin
            set_in(tbl[i].s, tbl[i].p, tbl[i].a, tbl[i].t, tbl[i].r);
            tick(0);
            check("tbl_cnt", int'(bus.cnt), tbl[i].e_cnt);
            check("tbl_busy", int'(bus.busy), int'(tbl[i].e_busy));
            check("tbl_done", int'(bus.done), int'(tbl[i].e_done));
            check("tbl_periods", int'(bus.periods), tbl[i].e_per);
            $display("vec %0d: cnt=%0d busy=%0d done=%0d periods=%0d", i, bus.cnt, bus.busy, bus.done, bus.periods);
        end

        // Auto-reload tc = 3 for 12 cycles; tc input changed after start.
        set_in(1, 0, 0, 3, 1);
        tick(1);
        set_in(0, 0, 0, 7, 0);
        dones = 0; busy_drops = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus.done) dones++;
            if (!bus.busy) busy_drops++;
        end
        check("reload_dones", dones, 3);
        check("reload_periods", int'(bus.periods), 3);
        check("reload_busy_drops", busy_drops, 0);
        $display("reload: dones=%0d periods=%0d", dones, bus.periods);
        // Abort keeps periods.
        set_in(0, 0, 1, 7, 0);
        tick(1);
        check("abort_periods", int'(bus.periods), 3);
        check("abort_busy", int'(bus.busy), 0);
        $display("abort after reload: periods=%0d busy=%0d", bus.periods, bus.busy);

        // Pause 4 cycles at cnt = 4, tc = 9 one-shot: done at edge 14.
        set_in(1, 0, 0, 9, 0);
        tick(1);
        set_in(0, 0, 0, 9, 0);
        edges = 0;
        for (int i = 0; i < 4; i++) begin tick(1); edges++; end
        check("pause_pre_cnt", int'(bus.cnt), 4);
        bus.pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1); edges++;
            check("pause_hold_cnt", int'(bus.cnt), 4);
        end
        bus.pause = 1'b0;
        tick(1); edges++;
        check("pause_resume_cnt", int'(bus.cnt), 5);
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1); edges++;
            if (bus.done) seen = 1;
        end
        check("pause_done_seen", int'(seen), 1);
        check("pause_done_edge", edges, 14);
        $display("pause: done after %0d edges", edges);
        tick(1);

        // Abort at cnt = 6, tc = 10.
        set_in(1, 0, 0, 10, 0);
        tick(1);
        set_in(0, 0, 0, 10, 0);
        for (int i = 0; i < 6; i++) tick(1);
        check("abort_pre_cnt", int'(bus.cnt), 6);
        bus.abort = 1'b1;
        tick(1);
        check("abort_cnt", int'(bus.cnt), 0);
        check("abort_done", int'(bus.done), 0);
        bus.abort = 1'b0;
        tick(1);
        check("abort_no_late_done", int'(bus.done), 0);
        $display("abort: cnt=%0d busy=%0d", bus.cnt, bus.busy);

        // tc = 0 auto-reload: done every cycle, periods saturates.
        set_in(1, 0, 0, 0, 1);
        tick(1);
        set_in(0, 0, 0, 0, 0);
        dones = 0;
        for (int i = 0; i < 260; i++) begin
            tick(1);
            if (bus.done) dones++;
        end
        check("tc0_dones", dones, 260);
        check("tc0_periods", int'(bus.periods), 255);
        $display("tc0: dones=%0d periods=%0d", dones, bus.periods);
        // Reset mid-sequence clears everything.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstmid_periods", int'(bus.periods), 0);
        check("rstmid_done", int'(bus.done), 0);
        check("rstmid_busy", int'(bus.busy), 0);
        $display("reset mid: periods=%0d busy=%0d", bus.periods, bus.busy);

        // tc = 15 one-shot: reaches all-ones, done at edge 16.
        set_in(1, 0, 0, 15, 0);
        tick(1);
        set_in(0, 0, 0, 0, 0);
        edges = 0; max_cnt = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick(1); edges++;
            if (int'(bus.cnt) > max_cnt) max_cnt = int'(bus.cnt);
            if (bus.done) seen = 1;
        end
        check("tc15_max_cnt", max_cnt, 15);
        check("tc15_done_edge", edges, 16);
        $display("tc15: max=%0d done edge=%0d", max_cnt, edges);

        // Start held through DONE: back-to-back restart without IDLE.
        tick(1);
        set_in(1, 0, 0, 2, 0);
        tick(1);
        for (int i = 0; i < 3; i++) tick(1);
        check("b2b_done", int'(bus.done), 1);
        bus.tc = 4'd6;
        tick(1);
        check("b2b_busy", int'(bus.busy), 1);
        check("b2b_cnt", int'(bus.cnt), 0);
        check("b2b_periods", int'(bus.periods), 0);
        $display("back-to-back: busy=%0d cnt=%0d", bus.busy, bus.cnt);
        set_in(0, 0, 1, 0, 0);
        tick(1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.start  = ($urandom_range(0, 3) == 0);
            bus.pause  = ($urandom_range(0, 5) == 0);
            bus.abort  = ($urandom_range(0, 29) == 0);
            bus.tc     = W'($urandom_range(0, 15));
            bus.reload = $urandom_range(0, 1) != 0;
            reset      = ($urandom_range(0, 99) == 0);
            tick(1);
        end
        reset = 1'b0;
        $display("random: 3000 cycles");

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/upcntr_ctrl.md
UPCNTR_CTRL -- requirements
Module: upcntr_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, count and terminal-count width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a count sequence; sampled only in IDLE or DONE.
REQ-005 pause  input  1  level; freezes counting while high in RUN/HOLD.
REQ-006 abort  input  1  terminates an active sequence without a done pulse.
REQ-007 tc  input  WIDTH  terminal count; latched into tc_q when start is accepted.
REQ-008 reload  input  1  mode; latched into reload_q when start is accepted (1 = auto-reload, 0 = one-shot).
REQ-009 cnt  output  WIDTH  current count value, registered.
REQ-010 busy  output  1  high in RUN and HOLD, registered.
REQ-011 done  output  1  one-cycle pulse per completed period, registered.
REQ-012 periods  output  8  completed-period count since the last accepted start; saturates at 255.

Function
REQ-013 FSM states: IDLE, RUN, HOLD, DONE; encoding is free; no other reachable states.
REQ-014 IDLE: cnt = 0, busy = 0, done = 0; start -> RUN, latch tc/reload, cnt <= 0, periods <= 0.
REQ-015 RUN, no pause, cnt != tc_q: cnt <= cnt + 1.
REQ-016 RUN, no pause, cnt == tc_q, reload_q = 1: cnt <= 0, stay RUN, done <= 1, periods <= periods + 1 (saturating).
REQ-017 RUN, no pause, cnt == tc_q, reload_q = 0: -> DONE, cnt holds tc_q, done <= 1, periods <= periods + 1 (saturating).
REQ-018 Period length: tc_q + 1 cycles (cnt sequence 0..tc_q); tc = 0 yields a done pulse every cycle in reload mode.
REQ-019 One-shot latency: start accepted at edge k -> cnt == tc_q after edge k + tc_q -> done = 1 after edge k + tc_q + 1.
REQ-020 RUN with pause = 1: -> HOLD, cnt unchanged; pause wins over the terminal check in the same cycle.
REQ-021 HOLD: cnt frozen, busy = 1; pause = 0 -> RUN next edge; counting resumes from the held value.
REQ-022 DONE: lasts one cycle, busy = 0, cnt = tc_q; start = 1 -> RUN (back-to-back, new tc/reload latched, cnt <= 0, periods <= 0); otherwise -> IDLE, cnt <= 0.
REQ-023 abort = 1 in RUN or HOLD: -> IDLE, cnt <= 0, no done pulse; periods retains its value.
REQ-024 Priority per edge: reset > abort > pause > terminal/increment.
REQ-025 start is ignored in RUN and HOLD; changes to tc/reload after acceptance have no effect until the next accepted start.
REQ-026 done is deasserted on every cycle other than those defined in REQ-016/REQ-017.
REQ-027 cnt arithmetic is unsigned modulo 2^WIDTH; with tc_q = 2^WIDTH - 1, cnt reaches all-ones and then terminates or reloads to 0.

Reset
REQ-028 reset = 1 at a rising edge -> state IDLE, cnt = 0, busy = 0, done = 0, periods = 0, tc_q = 0, reload_q = 0, regardless of the current state or other inputs.
REQ-029 reset asserted mid-sequence aborts the sequence with no done pulse; start is not accepted in any cycle in which reset = 1.
REQ-030 The first start is accepted on the first edge after reset deasserts.

Verification
REQ-031 One-shot: tc = 5, reload = 0, start pulse -> cnt 0,1,2,3,4,5 on successive cycles; then done = 1 for one cycle with busy = 0, cnt = 5, periods = 1; then cnt = 0 in IDLE.
REQ-032 Auto-reload: tc = 3, reload = 1, run 12 cycles -> done pulses every 4 cycles, cnt wraps 3 -> 0, periods = 3, busy stays 1.
REQ-033 Pause: tc = 9 one-shot, pause high for 4 cycles while cnt = 4 -> cnt holds at 4 for 4 cycles, resumes at 5; done occurs 4 cycles later than without the pause.
REQ-034 Abort and reset: abort at cnt = 6 (tc = 10) -> IDLE, cnt = 0, no done; repeat with reset instead of abort -> all outputs 0, periods = 0.
REQ-035 Edge cases: tc = 0, reload = 1 -> done high every cycle and periods saturates at 255; tc = 15 one-shot -> cnt reaches 15, then done; start held in DONE -> restart with no IDLE cycle.
